pc_fetch: RTL

Instruction-fetch stage of the 5-stage MIPS core. It sits directly upstream of the IF/ID pipeline latch. It owns the PC and issues word fetches on a variable-latency instruction-bus handshake. It delivers if_pc/if_inst to IF/ID and raises stallreq_if to the stall controller while no instruction is ready. It also applies branch redirects from ID (including ones that arrive during a fetch stall) and flush redirects from the exception unit.

---
 rtl/pc_fetch_pkg.sv | 4 +
 rtl/pc_fetch.sv | 88 ++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types for the instruction-fetch stage
package pc_fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: owns the PC, fetches over a variable-latency ibus, feeds IF/ID
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);
  fetch_state_t state;
  logic [31:0] pc, req_addr, inst_buf, br_tgt, next_pc;
  logic br_pend, valid, consume;
  always_comb begin
    valid       = (state == FETCH && ibus_ack) || state == HOLD;
    consume     = valid && !stall[0] && !flush;
    next_pc     = branch_flag_i ? branch_target_i : br_pend ? br_tgt : pc + 32'd4;
    ibus_req    = state == FETCH || state == DISCARD;
    ibus_addr   = req_addr;
    if_pc       = pc;
    if_inst     = state == HOLD ? inst_buf : (state == FETCH && ibus_ack) ? ibus_rdata : 32'd0;
    stallreq_if = !valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inst_buf <= '0;
      br_pend  <= 1'b0;
      br_tgt   <= '0;
    end else begin
      if (flush || consume) br_pend <= 1'b0;
      else if (branch_flag_i) begin
        br_pend <= 1'b1;
        br_tgt  <= branch_target_i;
      end
      case (state)
        IDLE: begin
          state <= FETCH;
          if (flush) begin
            pc       <= new_pc;
            req_addr <= new_pc;
          end
        end
        FETCH: begin
          if (flush) begin
            pc <= new_pc;
            if (ibus_ack) req_addr <= new_pc;
            else state <= DISCARD;
          end else if (consume) begin
            pc       <= next_pc;
            req_addr <= next_pc;
          end else if (ibus_ack) begin
            state    <= HOLD;
            inst_buf <= ibus_rdata;
          end
        end
        HOLD: begin
          if (flush || consume) begin
            state    <= FETCH;
            pc       <= flush ? new_pc : next_pc;
            req_addr <= flush ? new_pc : next_pc;
          end
        end
        default: begin
          // the stale response is dropped; refetch from the latest redirect
          if (flush) pc <= new_pc;
          if (ibus_ack) begin
            state    <= FETCH;
            req_addr <= flush ? new_pc : pc;
          end
        end
      endcase
    end
  end
endmodule
